// File: rtl/ripple_add_arbiter.sv
// Round-robin arbiter sharing one 4-bit ripple adder; grant 1 cycle after accept, result valid 2 cycles after accept.
// Backpressure: response held stable in RESP until i_resp_ready; no new request is sampled until then.
module ripple (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [4:0] sum
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar k = 0; k < 4; k++) begin : g_fa
        assign sum[k]  = a[k] ^ b[k] ^ c[k];
        assign c[k+1]  = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end

    assign sum[4] = c[4];
endmodule

module ripple_add_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [4*NUM_REQ-1:0]   i_term1,
    input  logic [4*NUM_REQ-1:0]   i_term2,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_valid,
    input  logic                   i_resp_ready,
    output logic [4:0]             o_result,
    output logic [ID_W-1:0]        o_id,
    output logic                   o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] winner;
    logic [ID_W:0]   cand;
    logic            any_req;
    logic [ID_W-1:0] id_q;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [4:0]      add_sum;

    ripple u_ripple (
        .a   (op_a),
        .b   (op_b),
        .cin (1'b0),
        .sum (add_sum)
    );

    // First set request at or after ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!any_req && i_req[cand[ID_W-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[ID_W-1:0];
            end
        end
    end

    assign ptr_nxt = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (i_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        if (state != IDLE) begin
            o_busy = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr      <= '0;
            id_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            o_grant  <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_id     <= '0;
        end else begin
            o_grant <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a    <= i_term1[{winner, 2'b00} +: 4];
                        op_b    <= i_term2[{winner, 2'b00} +: 4];
                        id_q    <= winner;
                        o_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        ptr     <= ptr_nxt;
                    end
                end
                EXEC: begin
                    o_result <= add_sum;
                    o_id     <= id_q;
                    o_valid  <= 1'b1;
                end
                RESP: begin
                    if (i_resp_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ripple_add_arbiter.sv
// Directed plus random bench for ripple_add_arbiter against a transaction-level round-robin model.
module tb_ripple_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] term1;
    logic [15:0] term2;
    logic [3:0]  grant;
    logic        valid;
    logic        resp_ready;
    logic [4:0]  result;
    logic [1:0]  id;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    ripple_add_arbiter #(.NUM_REQ(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_term1      (term1),
        .i_term2      (term2),
        .o_grant      (grant),
        .o_valid      (valid),
        .i_resp_ready (resp_ready),
        .o_result     (result),
        .o_id         (id),
        .o_busy       (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_grant"},  32'(grant),  32'd0);
        check({tag, "_valid"},  32'(valid),  32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_id"},     32'(id),     32'd0);
        check({tag, "_busy"},   32'(busy),   32'd0);
    endtask

    // One full operation starting from IDLE; requester k's operands placed in its slot.
    task automatic do_op(input string tag, input logic [3:0] r, input logic [3:0] a,
                         input logic [3:0] b, input int stall);
        int w;
        logic [4:0] held;
        w = pick(r, m_ptr);
        req = r;
        term1 = 16'($urandom);
        term2 = 16'($urandom);
        if (w >= 0) begin
            term1[4*w +: 4] = a;
            term2[4*w +: 4] = b;
        end
        resp_ready = 1'b0;
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        m_ptr = (w + 1) % 4;
        req = 4'b0000;
        term1 = 16'($urandom);
        term2 = 16'($urandom);
        tick();
        check({tag, "_valid"},  32'(valid),  32'd1);
        check({tag, "_result"}, 32'(result), 32'(a) + 32'(b));
        check({tag, "_id"},     32'(id),     32'(w));
        check({tag, "_nogrant"}, 32'(grant), 32'd0);
        held = result;
        for (int s = 0; s < stall; s++) begin
            req = 4'($urandom);
            tick();
            check({tag, "_hold_valid"},  32'(valid),  32'd1);
            check({tag, "_hold_result"}, 32'(result), 32'(held));
            check({tag, "_hold_id"},     32'(id),     32'(w));
            check({tag, "_hold_grant"},  32'(grant),  32'd0);
        end
        req = 4'b0000;
        resp_ready = 1'b1;
        tick();
        check({tag, "_drop"}, 32'(valid), 32'd0);
        check({tag, "_idle"}, 32'(busy),  32'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        req = '0;
        term1 = '0;
        term2 = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        do_op("single", 4'b0001, 4'h9, 4'h8, 0);

        // All four held high: one grant every 3 cycles in rotating order.
        req = 4'b1111;
        resp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            w = pick(4'b1111, m_ptr);
            check("rr_grant", 32'(grant), 32'(4'b0001 << w));
            m_ptr = (w + 1) % 4;
            tick();
            check("rr_valid", 32'(valid), 32'd1);
            check("rr_id",    32'(id),    32'(w));
            tick();
            check("rr_gap", 32'(grant), 32'd0);
        end
        req = 4'b0000;
        resp_ready = 1'b0;
        tick();
        tick();
        tick();
        check("rr_settle", 32'(busy), 32'd0);

        do_op("backpressure", 4'b0001, 4'hF, 4'hF, 5);

        // Force ptr to 3 via a grant to 2, then only requester 1 asks.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        do_op("to_two", 4'b0100, 4'h3, 4'h1, 0);
        check("wrap_ptr_model", 32'(m_ptr), 32'd3);
        do_op("wrap", 4'b0010, 4'h0, 4'h0, 0);

        // Reset during EXEC.
        req = 4'b0001;
        tick();
        check("rst_exec_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_exec");
        tick();
        check("rst_exec_noresp", 32'(valid), 32'd0);
        m_ptr = 0;

        // Reset during RESP.
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        check("rst_resp_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_resp");
        tick();
        check("rst_resp_noresp", 32'(valid), 32'd0);
        m_ptr = 0;
        do_op("after_rst", 4'b1000, 4'h7, 4'h6, 0);

        // Requester 2 pulses while the arbiter is in RESP and is never served.
        req = 4'b0001;
        tick();
        w = pick(4'b0001, m_ptr);
        check("late_grant", 32'(grant), 32'(4'b0001 << w));
        m_ptr = (w + 1) % 4;
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("late_nogrant", 32'(grant), 32'd0);
        check("late_id", 32'(id), 32'd0);
        req = 4'b0000;
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("late_idle", 32'(busy), 32'd0);
        tick();
        check("late_none", 32'(grant), 32'd0);
        check("late_none_busy", 32'(busy), 32'd0);
        do_op("late_next", 4'b0001, 4'h2, 4'h5, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                tick();
                check("rand_idle_grant", 32'(grant), 32'd0);
                check("rand_idle_busy",  32'(busy),  32'd0);
            end
            do_op("rand", 4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ripple_add_arbiter.md
# ripple_add_arbiter

Round-robin arbiter and sequencer that shares a single 4-bit ripple-carry adder (`ripple`, 4+4 → 5-bit result, carry-in tied 0) between up to NUM_REQ requesters. It accepts one request at a time and registers the winner's operands. It drives the shared adder from those registers and returns the registered 5-bit sum with the requester's index over a valid/ready response channel. It sits between requester logic and the adder instance; requesters never drive the adder directly.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- ID_W, $clog2(NUM_REQ), width of requester index (derived, not overridden)
- i_clk  input  1  clock; all logic rising-edge
- i_rst  input  1  reset; synchronous, active-high
- i_req  input  NUM_REQ  per-requester request level; held until own grant seen
- i_term1  input  4*NUM_REQ  packed operand A; requester k at [4k+3:4k]
- i_term2  input  4*NUM_REQ  packed operand B; same packing
- o_grant  output  NUM_REQ  one-hot, one-cycle registered pulse: request k accepted
- o_valid  output  1  response valid
- i_resp_ready  input  1  response consumer ready
- o_result  output  5  {carry, sum} of granted operands
- o_id  output  ID_W  index of requester owning o_result
- o_busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any i_req bit set, winner = first set bit searching from ptr upward with wrap (ptr, ptr+1, …, NUM_REQ-1, 0, …).
  - Latch winner's 4-bit operands into op_a/op_b.
  - Latch winner index into id_q; set o_grant[winner]=1 for next cycle.
  - ptr ← (winner+1) mod NUM_REQ; → EXEC.
  - No request: stay IDLE; ptr unchanged.
- EXEC: adder driven from op_a/op_b (operands never taken from i_term* directly); o_result ← adder output, o_id ← id_q, o_valid ← 1; → RESP. i_req ignored.
- RESP: hold o_valid, o_result, o_id stable. If i_resp_ready=1 → o_valid ← 0, → IDLE; else stay.
- i_req is sampled only in IDLE. Requests rising or falling in EXEC/RESP have no effect.
- A requester deasserting before being granted is legal and is simply not served.
- Requester protocol: on seeing o_grant[k], drop i_req[k] next cycle (or keep it high to queue a further op). Operands may change the cycle after the grant pulse.
- Arithmetic: o_result = term1 + term2, zero-extended to 5 bits; o_result[4] is carry-out. No saturation.
- Reset (any state, including mid-operation): state IDLE, ptr 0, o_grant 0, o_valid 0, o_result 0, o_id 0, o_busy 0, op regs 0. An in-flight op is discarded with no response.

## Timing
- Request high in IDLE at cycle N → o_grant pulse in cycle N+1 (exactly one cycle) → o_valid high from N+2.
- If i_resp_ready is high at N+2: o_valid low at N+3, IDLE at N+3. A new accept can occur at N+3 and its grant appears at N+4.
- Minimum op period: 3 cycles. Each cycle of i_resp_ready low adds one cycle.
- o_busy is high N+1 through the cycle the response is accepted.
- Only one outstanding operation at any time.
- o_grant is never asserted while o_valid is held in RESP.

## Test plan
- Reset then single request: i_req=4'b0001, term1=4'h9, term2=4'h8 → grant 4'b0001 one cycle later; o_valid next cycle with o_result=5'h11, o_id=0; with i_resp_ready=1, o_valid drops the following cycle.
- Round-robin fairness: all four i_req held high continuously, i_resp_ready=1 → grant order 0,1,2,3,0,… with one grant every 3 cycles; each o_id matches its grant.
- Backpressure: i_resp_ready held low 5 cycles with o_result=5'h1E (F+F) → o_valid, o_result, o_id stable for all 5 cycles; no grants issued; release → o_valid low the next cycle.
- Wrap and skip: ptr at 3 (after a grant to 2), i_req=4'b0010 → grant index 1, ptr becomes 2; zero operands → o_result=0.
- Reset mid-op: assert i_rst in EXEC, and separately in RESP → next cycle all outputs 0, no response delivered; subsequent request with i_req=4'b1000 is granted (ptr restarted at 0, winner 3).
- Late drop: i_req[2] raised then lowered while busy in RESP → never granted; no response with o_id=2.
